// File: rtl/dly_tdc_pkg.sv
// dly_tdc_pkg: shared states and width helper for the delay-chain monitor
package dly_tdc_pkg;
  typedef enum logic [2:0] {IDLE, FIRE, CAPT, SYNC, ACC, CLR} state_t;
  function automatic int cw_of(input int ntap);
    return $clog2(ntap + 1);
  endfunction
endpackage

// File: rtl/dly_tdc_if.sv
// dly_tdc_if: controller and chain-side signals of the delay monitor
interface dly_tdc_if import dly_tdc_pkg::*; #(parameter int NTAP = 32) ();
  logic start;
  logic [NTAP-1:0] tap;
  logic launch, busy, done;
  logic [cw_of(NTAP)-1:0] code;
  logic ovf, err;
  modport master (output start, tap, input launch, busy, done, code, ovf, err);
  modport slave (input start, tap, output launch, busy, done, code, ovf, err);
endinterface

// File: rtl/dly_tdc_encoder.sv
// dly_tdc_encoder: thermometer-to-count converter with bubble correction
module dly_tdc_encoder import dly_tdc_pkg::*; #(parameter int NTAP = 32) (
  input  logic [NTAP-1:0] tap,
  output logic [cw_of(NTAP)-1:0] code
);
  localparam int CW = cw_of(NTAP);
  logic run;
  // count the unbroken run of ones from tap[0]; bits past the first zero are bubbles
  always_comb begin
    code = '0;
    run = 1'b1;
    for (int i = 0; i < NTAP; i++) begin
      run = run & tap[i];
      code = code + CW'(run);
    end
  end
endmodule

// File: rtl/dly_tdc_monitor.sv
// dly_tdc_monitor: launches edges into a tapped delay chain and averages the captured tap counts
module dly_tdc_monitor import dly_tdc_pkg::*; #(
  parameter int NTAP = 32,
  parameter int AVG_LOG2 = 2,
  parameter int CLR_MAX = 15
) (
  input logic clk,
  input logic rst,
  dly_tdc_if.slave bus
);
  localparam int CW = cw_of(NTAP);
  localparam int AW = CW + AVG_LOG2;
  localparam int SW = AVG_LOG2 + 1;
  localparam int TW = $clog2(CLR_MAX + 1);
  localparam logic [SW-1:0] SLAST = SW'((1 << AVG_LOG2) - 1);
  state_t state, nxt;
  logic [NTAP-1:0] cap, syn;
  logic [CW-1:0] enc;
  logic [AW-1:0] acc;
  logic [SW-1:0] cnt;
  logic [TW-1:0] tmr;
  logic ovf_s, clr_ok, clr_to, fin;
  dly_tdc_encoder #(.NTAP(NTAP)) u_enc (.tap(syn), .code(enc));
  assign clr_ok = tmr != '0 && syn == '0;
  assign clr_to = !clr_ok && tmr == TW'(CLR_MAX - 1);
  assign bus.busy = state != IDLE;
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // sequencing; CLR leaves on a settled chain, on the last sample, or on timeout
  always_comb begin
    nxt = state;
    fin = 1'b0;
    case (state)
      IDLE: nxt = bus.start ? FIRE : IDLE;
      FIRE: nxt = CAPT;
      CAPT: nxt = SYNC;
      SYNC: nxt = ACC;
      ACC: nxt = CLR;
      CLR: begin
        fin = clr_to || (clr_ok && cnt == SLAST);
        nxt = fin ? IDLE : clr_ok ? FIRE : CLR;
      end
      default: nxt = IDLE;
    endcase
  end
  // launch flop, capture/sync pipe, accumulator, sample counter, clear timer and held results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap <= '0;
      syn <= '0;
      acc <= '0;
      cnt <= '0;
      tmr <= '0;
      ovf_s <= 1'b0;
      bus.launch <= 1'b0;
      bus.done <= 1'b0;
      bus.code <= '0;
      bus.ovf <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      bus.launch <= nxt == FIRE;
      if (state == FIRE || state == ACC || state == CLR) cap <= bus.tap;
      syn <= cap;
      tmr <= state == CLR ? tmr + TW'(1) : '0;
      if (state == IDLE && bus.start) begin
        acc <= '0;
        cnt <= '0;
        ovf_s <= 1'b0;
      end
      if (state == ACC) begin
        acc <= acc + AW'(enc);
        ovf_s <= ovf_s | (&syn);
      end
      if (state == CLR && nxt == FIRE) cnt <= cnt + SW'(1);
      bus.done <= fin;
      if (fin) begin
        bus.code <= acc[AW-1:AVG_LOG2];
        bus.ovf <= ovf_s;
        bus.err <= clr_to;
      end
    end
  end
endmodule
